sig_gen_pwm: RTL

- Synchronous, parametrised square/pulse-wave generator. Successor to the free-running enable-gated toggler.
- Programmable high and low phase lengths in clock cycles, continuous or counted-burst mode, period counter, done pulse.
- Drives test-stimulus and timing signals inside exercise-level designs.
- One clock domain; all outputs registered.

---
 rtl/sig_gen_pwm.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sig_gen_pwm.sv
// rtl/sig_gen_pwm.sv - programmable square/pulse-wave generator, continuous or counted-burst
// Optional build macro SIGGEN_GRACEFUL_STOP_EN: continuous-mode stop finishes the current period.

module sig_gen_pwm #(
    parameter int   CNT_W      = 8,
    parameter int   BURST_W    = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               mode,
    input  logic [CNT_W-1:0]   high_len,
    input  logic [CNT_W-1:0]   low_len,
    input  logic [BURST_W-1:0] burst_len,
    output logic               sig,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] period_cnt
);

`ifdef SIGGEN_GRACEFUL_STOP_EN
    localparam bit GRACEFUL = 1'b1;
`else
    localparam bit GRACEFUL = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   phase_cnt;
    logic [CNT_W-1:0]   phase_cnt_n;
    logic [CNT_W-1:0]   hi_q;
    logic [CNT_W-1:0]   lo_q;
    logic [BURST_W-1:0] bl_q;
    logic               mode_q;
    logic               enable_d;
    logic [BURST_W-1:0] period_cnt_n;
    logic [BURST_W-1:0] pc_inc;
    logic               start;
    logic               abort;
    logic               sig_n;
    logic               busy_n;
    logic               done_n;

    // Zero-length settings are clamped to one cycle/period at latch time.
    logic [CNT_W-1:0]   hi_eff;
    logic [CNT_W-1:0]   lo_eff;
    logic [BURST_W-1:0] bl_eff;

    assign hi_eff = (high_len == '0) ? CNT_W'(1) : high_len;
    assign lo_eff = (low_len == '0) ? CNT_W'(1) : low_len;
    assign bl_eff = (burst_len == '0) ? BURST_W'(1) : burst_len;

    // Burst counting saturates; continuous counting wraps.
    assign pc_inc = (mode_q && (period_cnt == '1)) ? period_cnt : period_cnt + BURST_W'(1);

    assign abort = !mode_q && !enable && !GRACEFUL;

    always_comb begin
        state_n      = state;
        phase_cnt_n  = phase_cnt;
        period_cnt_n = period_cnt;
        start        = 1'b0;
        case (state)
            S_IDLE: begin
                if (mode ? (enable && !enable_d) : enable) begin
                    start        = 1'b1;
                    state_n      = S_HIGH;
                    phase_cnt_n  = '0;
                    period_cnt_n = '0;
                end
            end
            S_HIGH: begin
                if (abort) begin
                    state_n     = S_IDLE;
                    phase_cnt_n = '0;
                end else if (phase_cnt == hi_q - CNT_W'(1)) begin
                    state_n     = S_LOW;
                    phase_cnt_n = '0;
                end else begin
                    phase_cnt_n = phase_cnt + CNT_W'(1);
                end
            end
            S_LOW: begin
                // A period that completes on the same edge as a stop still counts.
                if (phase_cnt == lo_q - CNT_W'(1)) begin
                    phase_cnt_n  = '0;
                    period_cnt_n = pc_inc;
                    if (mode_q) begin
                        state_n = (pc_inc == bl_q) ? S_DONE : S_HIGH;
                    end else begin
                        state_n = enable ? S_HIGH : S_IDLE;
                    end
                end else if (abort) begin
                    state_n     = S_IDLE;
                    phase_cnt_n = '0;
                end else begin
                    phase_cnt_n = phase_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        sig_n  = IDLE_LEVEL;
        busy_n = 1'b0;
        done_n = 1'b0;
        case (state_n)
            S_HIGH: begin
                sig_n  = 1'b1;
                busy_n = 1'b1;
            end
            S_LOW: begin
                sig_n  = 1'b0;
                busy_n = 1'b1;
            end
            S_DONE: begin
                done_n = 1'b1;
            end
            default: begin
                sig_n = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            phase_cnt  <= '0;
            period_cnt <= '0;
            enable_d   <= 1'b0;
            hi_q       <= CNT_W'(1);
            lo_q       <= CNT_W'(1);
            bl_q       <= BURST_W'(1);
            mode_q     <= 1'b0;
            sig        <= IDLE_LEVEL;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            phase_cnt  <= phase_cnt_n;
            period_cnt <= period_cnt_n;
            enable_d   <= enable;
            sig        <= sig_n;
            busy       <= busy_n;
            done       <= done_n;
            if (start) begin
                hi_q   <= hi_eff;
                lo_q   <= lo_eff;
                bl_q   <= bl_eff;
                mode_q <= mode;
            end
        end
    end

endmodule
